// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared scan-path types, MISR step function and default polynomials
package scan_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_SHIFT
    } scan_state_t;

    localparam int MISR_MAX_WIDTH = 64;

    localparam logic [3:0]  MISR_POLY_4  = 4'hC;
    localparam logic [7:0]  MISR_POLY_8  = 8'hB8;
    localparam logic [15:0] MISR_POLY_16 = 16'hB400;
    localparam logic [31:0] MISR_POLY_32 = 32'h80200003;

    // Operates on a zero-extended signature so one function serves every width up to 64.
    function automatic logic [MISR_MAX_WIDTH-1:0] misr_step(
        input logic [MISR_MAX_WIDTH-1:0] sig,
        input logic                      b,
        input logic [MISR_MAX_WIDTH-1:0] poly
    );
        logic fb;
        fb = sig[0] ^ b;
        return (sig >> 1) ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/scan_misr.sv
// rtl/scan_misr.sv - serial-input Galois MISR with enable and synchronous clear
module scan_misr
    import scan_pkg::*;
#(
    parameter int                WIDTH = 16,
    parameter logic [WIDTH-1:0]  POLY  = MISR_POLY_16
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             EN,
    input  logic             CLEAR,
    input  logic             DIN,
    output logic [WIDTH-1:0] SIGNATURE
);

    logic [MISR_MAX_WIDTH-1:0] step_full;
    logic                      unused_step_hi;

    assign step_full      = misr_step(MISR_MAX_WIDTH'(SIGNATURE), DIN, MISR_MAX_WIDTH'(POLY));
    assign unused_step_hi = ^step_full;

    // Clear has priority so a coincident shifted bit is dropped rather than folded.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            SIGNATURE <= '0;
        end else if (CLEAR) begin
            SIGNATURE <= '0;
        end else if (EN) begin
            SIGNATURE <= step_full[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/scan_response_unloader.sv
// rtl/scan_response_unloader.sv - serialises captured scan chain LSB-first and compacts it into a MISR
module scan_response_unloader
    import scan_pkg::*;
#(
    parameter int                    CHAIN_LEN  = 16,
    parameter int                    MISR_WIDTH = 16,
    parameter logic [MISR_WIDTH-1:0] MISR_POLY  = MISR_POLY_16,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                  CLOCK,
    input  logic                  RESET_N,
    input  logic                  CAP_VALID,
    output logic                  CAP_READY,
    input  logic [CHAIN_LEN-1:0]  CAP_DATA,
    output logic                  SO,
    output logic                  SO_VALID,
    input  logic                  SO_READY,
    output logic                  SO_LAST,
    input  logic                  SIG_CLEAR,
    output logic [MISR_WIDTH-1:0] SIGNATURE,
    output logic [CNT_WIDTH-1:0]  PATTERN_COUNT,
    output logic                  BUSY
);

    localparam int            BW       = $clog2(CHAIN_LEN);
    localparam logic [BW-1:0] LAST_BIT = BW'(CHAIN_LEN - 1);

    scan_state_t          state, state_next;
    logic [CHAIN_LEN-1:0] shreg;
    logic [BW-1:0]        bitcnt;
    logic                 cap_fire;
    logic                 bit_fire;

    always_comb begin
        state_next = state;
        CAP_READY  = 1'b0;
        SO_VALID   = 1'b0;
        SO         = 1'b0;
        SO_LAST    = 1'b0;
        BUSY       = 1'b0;
        case (state)
            ST_IDLE: begin
                CAP_READY = 1'b1;
                if (CAP_VALID) state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                SO_VALID = 1'b1;
                BUSY     = 1'b1;
                SO       = shreg[0];
                SO_LAST  = (bitcnt == LAST_BIT);
                if (SO_READY && SO_LAST) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign cap_fire = CAP_VALID & CAP_READY;
    assign bit_fire = SO_VALID & SO_READY;

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state  <= ST_IDLE;
            shreg  <= '0;
            bitcnt <= '0;
        end else begin
            state <= state_next;
            if (cap_fire) begin
                shreg  <= CAP_DATA;
                bitcnt <= '0;
            end else if (bit_fire) begin
                shreg  <= {1'b0, shreg[CHAIN_LEN-1:1]};
                bitcnt <= bitcnt + BW'(1);
            end
        end
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            PATTERN_COUNT <= '0;
        end else if (SIG_CLEAR) begin
            PATTERN_COUNT <= '0;
        end else if (bit_fire && SO_LAST) begin
            PATTERN_COUNT <= PATTERN_COUNT + CNT_WIDTH'(1);
        end
    end

    scan_misr #(
        .WIDTH (MISR_WIDTH),
        .POLY  (MISR_POLY)
    ) u_misr (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .EN        (bit_fire),
        .CLEAR     (SIG_CLEAR),
        .DIN       (SO),
        .SIGNATURE (SIGNATURE)
    );

endmodule
